// File: rtl/nf_trace_pkg.sv
// Shared state encoding and trace-entry layout for the pipeline trace buffer.
// An entry is {cycle, pc, instr[STAGES-1:0]} with stage 0 in the LSBs.
package nf_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } trace_state_e;

   localparam int PC_W      = 32;
   localparam int INSTR_W   = 32;
   localparam int INSTR_LSB = 0;

   function automatic int entry_w(input int stages, input int cyc_w);
      return cyc_w + PC_W + stages * INSTR_W;
   endfunction

   function automatic int pc_lsb(input int stages);
      return stages * INSTR_W;
   endfunction

   function automatic int cyc_lsb(input int stages);
      return stages * INSTR_W + PC_W;
   endfunction

endpackage

// File: rtl/nf_trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old contents.
module nf_trace_ram #(
   parameter int WIDTH = 192,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [WIDTH-1:0]         o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge clk) begin
      if (!resetn)      r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/nf_pipe_trace.sv
// Synthesizable pipeline tracer: logs {cycle, pc, stage instructions} per retiring
// cycle into a circular RAM with PC trigger, pre-trigger history and host pop.
module nf_pipe_trace
   import nf_trace_pkg::*;
#(
   parameter int STAGES = 4,
   parameter int DEPTH  = 64,
   parameter int CYC_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          arm,
   input  logic                          abort,
   input  logic                          wrap_mode,
   input  logic                          trig_pc_en,
   input  logic [31:0]                   trig_pc,
   input  logic [CNT_W-1:0]              post_cnt,
   input  logic                          cpu_vld,
   input  logic [31:0]                   pc_in,
   input  logic [STAGES*32-1:0]          instr_in,
   input  logic                          rd_en,
   output logic [CYC_W+32+STAGES*32-1:0] rd_data,
   output logic                          rd_vld,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          lost,
   output logic [1:0]                    state,
   output logic [CYC_W-1:0]              cycle_cnt
);
   // state   | meaning
   // IDLE    | not capturing; buffer readable
   // ARMED   | waiting for trigger; wrap mode logs history
   // CAPTURE | logging the post-trigger window
   // DONE    | window complete or buffer full; buffer readable

   localparam int           AW       = $clog2(DEPTH);
   localparam int           EW       = entry_w(STAGES, CYC_W);
   localparam int           PC_LSB   = pc_lsb(STAGES);
   localparam int           CYC_LSB  = cyc_lsb(STAGES);
   localparam logic [AW:0]  CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]  CNT_LAST = (AW+1)'(DEPTH - 1);

   trace_state_e     r_state, w_state_nxt;
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_lost, r_rd_vld;
   logic [CYC_W-1:0] r_cycle;
   logic             r_wrap, r_trig_en;
   logic [31:0]      r_trig_pc;
   logic [CNT_W-1:0] r_post_len, r_post_left;

   logic             w_full, w_empty, w_pop, w_wr, w_ovw, w_trig;
   logic             w_load_post, w_cyc_inc;
   logic [EW-1:0]    w_entry, w_rd_data;

   assign w_full  = (r_count == CNT_FULL);
   assign w_empty = (r_count == '0);
   assign w_pop   = rd_en && !w_empty;
   assign w_trig  = !r_trig_en || (pc_in == r_trig_pc);
   // A pop in the same cycle frees the oldest slot, so nothing unread is destroyed.
   assign w_ovw   = w_wr && w_full && !w_pop;

   always_comb begin
      w_entry = '0;
      w_entry[INSTR_LSB +: STAGES*INSTR_W] = instr_in;
      w_entry[PC_LSB +: PC_W]              = pc_in;
      w_entry[CYC_LSB +: CYC_W]            = r_cycle;
   end

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wr        = 1'b0;
      w_load_post = 1'b0;
      w_cyc_inc   = 1'b0;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else if (arm) begin
         w_state_nxt = ST_ARMED;
      end else begin
         unique case (r_state)
            ST_ARMED: begin
               w_cyc_inc = cpu_vld;
               w_wr      = cpu_vld && (r_wrap || w_trig);
               if (cpu_vld && w_trig) begin
                  w_load_post = 1'b1;
                  w_state_nxt = (r_post_len == CNT_W'(1)) ? ST_DONE : ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               w_cyc_inc = cpu_vld;
               w_wr      = cpu_vld;
               if (cpu_vld && ((r_post_left == CNT_W'(1)) ||
                               (!r_wrap && r_count == CNT_LAST && !w_pop)))
                  w_state_nxt = ST_DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_lost      <= 1'b0;
         r_rd_vld    <= 1'b0;
         r_cycle     <= '0;
         r_wrap      <= 1'b0;
         r_trig_en   <= 1'b0;
         r_trig_pc   <= '0;
         r_post_len  <= CNT_W'(1);
         r_post_left <= '0;
      end else begin
         r_rd_vld <= w_pop;
         if (arm && !abort) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_lost      <= 1'b0;
            r_cycle     <= '0;
            r_wrap      <= wrap_mode;
            r_trig_en   <= trig_pc_en;
            r_trig_pc   <= trig_pc;
            r_post_len  <= (post_cnt == '0) ? CNT_W'(1) : post_cnt;
            r_post_left <= '0;
         end else begin
            if (w_wr)           r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop || w_ovw) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop && !w_full) r_count <= r_count + 1'b1;
            else if (w_pop && !w_wr)       r_count <= r_count - 1'b1;
            if (w_ovw)      r_lost  <= 1'b1;
            if (w_cyc_inc)  r_cycle <= r_cycle + 1'b1;
            if (w_load_post)                          r_post_left <= r_post_len - 1'b1;
            else if (w_wr && r_state == ST_CAPTURE)   r_post_left <= r_post_left - 1'b1;
         end
      end
   end

   nf_trace_ram #(.WIDTH(EW), .DEPTH(DEPTH)) u_ram (
      .clk       (clk),
      .resetn    (resetn),
      .i_wr_en   (w_wr),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_entry),
      .i_rd_en   (w_pop),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   assign rd_data   = w_rd_data;
   assign rd_vld    = r_rd_vld;
   assign empty     = w_empty;
   assign full      = w_full;
   assign count     = r_count;
   assign lost      = r_lost;
   assign state     = r_state;
   assign cycle_cnt = r_cycle;

endmodule

// File: tb/tb_nf_pipe_trace.sv
// Bench for nf_pipe_trace: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the trace buffer.
module tb_nf_pipe_trace;
   localparam int STAGES = 4;
   localparam int DEPTH  = 64;
   localparam int CYC_W  = 32;
   localparam int CNT_W  = 16;
   localparam int EW     = CYC_W + 32 + STAGES*32;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 resetn = 1'b0;
   logic                 arm = 1'b0, abort = 1'b0, wrap_mode = 1'b0, trig_pc_en = 1'b0;
   logic [31:0]          trig_pc = '0;
   logic [CNT_W-1:0]     post_cnt = '0;
   logic                 cpu_vld = 1'b0;
   logic [31:0]          pc_in = '0;
   logic [STAGES*32-1:0] instr_in = '0;
   logic                 rd_en = 1'b0;
   logic [EW-1:0]        rd_data;
   logic                 rd_vld, empty, full, lost;
   logic [CW-1:0]        count;
   logic [1:0]           state;
   logic [CYC_W-1:0]     cycle_cnt;

   nf_pipe_trace #(.STAGES(STAGES), .DEPTH(DEPTH), .CYC_W(CYC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .arm(arm), .abort(abort), .wrap_mode(wrap_mode),
      .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .post_cnt(post_cnt), .cpu_vld(cpu_vld),
      .pc_in(pc_in), .instr_in(instr_in), .rd_en(rd_en), .rd_data(rd_data), .rd_vld(rd_vld),
      .empty(empty), .full(full), .count(count), .lost(lost), .state(state),
      .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model: 0=IDLE 1=ARMED 2=CAPTURE 3=DONE
   logic [EW-1:0]    m_q[$];
   int               m_state = 0;
   logic [CYC_W-1:0] m_cycle = '0;
   bit               m_lost = 0;
   bit               m_rd_vld = 0;
   logic [EW-1:0]    m_rd_data = '0;
   bit               m_wrap = 0, m_trig_en = 0;
   logic [31:0]      m_trig_pc = '0;
   int               m_post = 1, m_rem = 0;

   task automatic model_edge();
      bit            pop, cap, trig;
      int            pre;
      logic [EW-1:0] ent;
      if (!resetn) begin
         m_q.delete(); m_state = 0; m_cycle = '0; m_lost = 0;
         m_rd_vld = 0; m_rd_data = '0;
         return;
      end
      pre = m_state;
      pop = rd_en && (m_q.size() > 0);
      m_rd_vld = pop;
      if (pop) m_rd_data = m_q[0];
      if (abort) begin
         if (pop) void'(m_q.pop_front());
         m_state = 0;
      end else if (arm) begin
         m_q.delete(); m_lost = 0; m_cycle = '0;
         m_wrap = wrap_mode; m_trig_en = trig_pc_en; m_trig_pc = trig_pc;
         m_post = (post_cnt == 0) ? 1 : int'(post_cnt);
         m_state = 1;
      end else begin
         cap = 0;
         ent = {m_cycle, pc_in, instr_in};
         if (pre == 1 && cpu_vld) begin
            trig = !m_trig_en || (pc_in == m_trig_pc);
            cap  = m_wrap || trig;
            if (trig) begin
               m_rem   = m_post - 1;
               m_state = (m_rem == 0) ? 3 : 2;
            end
         end else if (pre == 2 && cpu_vld) begin
            cap = 1;
            m_rem--;
            if (m_rem == 0) m_state = 3;
         end
         if ((pre == 1 || pre == 2) && cpu_vld) m_cycle++;
         if (pop) void'(m_q.pop_front());
         if (cap) begin
            if (m_q.size() == DEPTH) begin
               void'(m_q.pop_front());
               m_lost = 1;
            end
            m_q.push_back(ent);
            if (!m_wrap && m_q.size() == DEPTH) m_state = 3;
         end
      end
   endtask

   task automatic step(input bit a_arm, input bit a_abort, input bit a_vld,
                       input logic [31:0] a_pc, input bit a_rd);
      @(negedge clk);
      arm = a_arm; abort = a_abort; cpu_vld = a_vld; pc_in = a_pc; rd_en = a_rd;
      for (int s = 0; s < STAGES; s++) instr_in[s*32 +: 32] = $urandom();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_arm(input bit w, input bit te, input logic [31:0] tp, input int p);
      wrap_mode = w; trig_pc_en = te; trig_pc = tp; post_cnt = CNT_W'(p);
      step(1, 0, 0, '0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 0; arm = 0; abort = 0; cpu_vld = 0; rd_en = 0;
      @(posedge clk);
      model_edge();
      #1;
      @(negedge clk);
      resetn = 1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests += 8;
      if (state !== 2'd0)     begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state); end
      if (count !== '0)       begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count); end
      if (empty !== 1'b1)     begin n_fail++; $display("FAIL rst_empty got=%0b exp=1", empty); end
      if (full !== 1'b0)      begin n_fail++; $display("FAIL rst_full got=%0b exp=0", full); end
      if (rd_vld !== 1'b0)    begin n_fail++; $display("FAIL rst_rd_vld got=%0b exp=0", rd_vld); end
      if (rd_data !== '0)     begin n_fail++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
      if (lost !== 1'b0)      begin n_fail++; $display("FAIL rst_lost got=%0b exp=0", lost); end
      if (cycle_cnt !== '0)   begin n_fail++; $display("FAIL rst_cycle got=%0d exp=0", cycle_cnt); end
   endtask

   task automatic test_immediate();
      do_arm(0, 0, '0, 5);
      for (int k = 0; k < 7; k++) step(0, 0, 1, 32'h1000 + 32'(k*4), 0);
      n_tests += 3;
      if (state !== 2'd3)      begin n_fail++; $display("FAIL imm_state got=%0d exp=3", state); end
      if (count !== CW'(5))    begin n_fail++; $display("FAIL imm_count got=%0d exp=5", count); end
      if (cycle_cnt !== 32'd5) begin n_fail++; $display("FAIL imm_cycle got=%0d exp=5", cycle_cnt); end
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, '0, 1);
         n_tests++;
         if (rd_vld !== (i < 5)) begin n_fail++; $display("FAIL imm_rd_vld pop=%0d got=%0b exp=%0b", i, rd_vld, i < 5); end
         if (i < 5) begin
            n_tests += 3;
            if (rd_data[EW-1 -: CYC_W] !== 32'(i))
               begin n_fail++; $display("FAIL imm_cyc pop=%0d got=%0d exp=%0d", i, rd_data[EW-1 -: CYC_W], i); end
            if (rd_data[STAGES*32 +: 32] !== 32'h1000 + 32'(i*4))
               begin n_fail++; $display("FAIL imm_pc pop=%0d got=%h exp=%h", i, rd_data[STAGES*32 +: 32], 32'h1000 + 32'(i*4)); end
            if (rd_data !== m_rd_data)
               begin n_fail++; $display("FAIL imm_data pop=%0d got=%h exp=%h", i, rd_data, m_rd_data); end
         end
      end
   endtask

   task automatic test_history();
      do_arm(1, 1, 32'h100, 8);
      for (int k = 0; k < 80; k++) begin
         step(0, 0, 1, 32'(k*4), 0);
         if (k == 63) begin
            n_tests += 2;
            if (full !== 1'b1) begin n_fail++; $display("FAIL hist_full63 got=%0b exp=1", full); end
            if (lost !== 1'b0) begin n_fail++; $display("FAIL hist_lost63 got=%0b exp=0", lost); end
         end
      end
      n_tests += 4;
      if (lost !== 1'b1)        begin n_fail++; $display("FAIL hist_lost got=%0b exp=1", lost); end
      if (count !== CW'(64))    begin n_fail++; $display("FAIL hist_count got=%0d exp=64", count); end
      if (state !== 2'd3)       begin n_fail++; $display("FAIL hist_state got=%0d exp=3", state); end
      if (cycle_cnt !== 32'd72) begin n_fail++; $display("FAIL hist_cycle got=%0d exp=72", cycle_cnt); end
      for (int i = 0; i < 64; i++) begin
         step(0, 0, 0, '0, 1);
         n_tests += 2;
         if (rd_data[EW-1 -: CYC_W] !== 32'(8 + i))
            begin n_fail++; $display("FAIL hist_cyc pop=%0d got=%0d exp=%0d", i, rd_data[EW-1 -: CYC_W], 8 + i); end
         if (rd_data[STAGES*32 +: 32] !== 32'((8 + i) * 4))
            begin n_fail++; $display("FAIL hist_pc pop=%0d got=%h exp=%h", i, rd_data[STAGES*32 +: 32], 32'((8 + i) * 4)); end
      end
      n_tests++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL hist_empty got=%0b exp=1", empty); end
   endtask

   task automatic test_stall();
      bit vseq[5] = '{1, 1, 0, 0, 1};
      do_arm(0, 0, '0, 3);
      for (int k = 0; k < 5; k++) begin
         step(0, 0, vseq[k], 32'h40 + 32'(k), 0);
         if (k == 3) begin
            n_tests++;
            if (count !== CW'(2)) begin n_fail++; $display("FAIL stall_hold got=%0d exp=2", count); end
         end
      end
      n_tests += 3;
      if (count !== CW'(3))    begin n_fail++; $display("FAIL stall_count got=%0d exp=3", count); end
      if (state !== 2'd3)      begin n_fail++; $display("FAIL stall_state got=%0d exp=3", state); end
      if (cycle_cnt !== 32'd3) begin n_fail++; $display("FAIL stall_cycle got=%0d exp=3", cycle_cnt); end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, '0, 1);
         n_tests++;
         if (rd_data[EW-1 -: CYC_W] !== 32'(i))
            begin n_fail++; $display("FAIL stall_cyc pop=%0d got=%0d exp=%0d", i, rd_data[EW-1 -: CYC_W], i); end
      end
   endtask

   task automatic test_nowrap_full();
      do_arm(0, 0, '0, 100);
      for (int k = 0; k < 70; k++) begin
         step(0, 0, 1, 32'(k*4), 0);
         if (k == 62) begin
            n_tests++;
            if (state !== 2'd2) begin n_fail++; $display("FAIL full_state62 got=%0d exp=2", state); end
         end
      end
      n_tests += 5;
      if (state !== 2'd3)       begin n_fail++; $display("FAIL full_state got=%0d exp=3", state); end
      if (count !== CW'(64))    begin n_fail++; $display("FAIL full_count got=%0d exp=64", count); end
      if (full !== 1'b1)        begin n_fail++; $display("FAIL full_flag got=%0b exp=1", full); end
      if (lost !== 1'b0)        begin n_fail++; $display("FAIL full_lost got=%0b exp=0", lost); end
      if (cycle_cnt !== 32'd64) begin n_fail++; $display("FAIL full_cycle got=%0d exp=64", cycle_cnt); end
   endtask

   task automatic test_back_to_back();
      int n_read = 0;
      do_arm(0, 0, '0, 10);
      for (int k = 0; k < 12; k++) begin
         step(0, 0, 1, 32'h200 + 32'(k*4), 1);
         if (k < 10) begin
            n_tests++;
            if (count !== CW'(1)) begin n_fail++; $display("FAIL b2b_count k=%0d got=%0d exp=1", k, count); end
         end
         if (rd_vld) begin
            n_tests++;
            if (rd_data[EW-1 -: CYC_W] !== 32'(n_read))
               begin n_fail++; $display("FAIL b2b_order got=%0d exp=%0d", rd_data[EW-1 -: CYC_W], n_read); end
            n_read++;
         end
      end
      n_tests += 3;
      if (n_read != 10)   begin n_fail++; $display("FAIL b2b_reads got=%0d exp=10", n_read); end
      if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got=%0b exp=1", empty); end
      if (state !== 2'd3) begin n_fail++; $display("FAIL b2b_state got=%0d exp=3", state); end
   endtask

   task automatic test_abort_reset();
      do_arm(0, 0, '0, 20);
      for (int k = 0; k < 6; k++) step(0, 0, 1, 32'h300 + 32'(k*4), 0);
      step(0, 1, 1, 32'h400, 0);
      n_tests += 3;
      if (state !== 2'd0)      begin n_fail++; $display("FAIL abort_state got=%0d exp=0", state); end
      if (count !== CW'(6))    begin n_fail++; $display("FAIL abort_count got=%0d exp=6", count); end
      if (cycle_cnt !== 32'd6) begin n_fail++; $display("FAIL abort_cycle got=%0d exp=6", cycle_cnt); end
      step(0, 0, 0, '0, 1);
      n_tests += 3;
      if (rd_vld !== 1'b1)              begin n_fail++; $display("FAIL abort_rd_vld got=%0b exp=1", rd_vld); end
      if (rd_data[STAGES*32 +: 32] !== 32'h300)
         begin n_fail++; $display("FAIL abort_pc got=%h exp=300", rd_data[STAGES*32 +: 32]); end
      if (count !== CW'(5))             begin n_fail++; $display("FAIL abort_pop_count got=%0d exp=5", count); end
      do_arm(1, 0, '0, 50);
      for (int k = 0; k < 4; k++) step(0, 0, 1, 32'h500 + 32'(k*4), 0);
      n_tests++;
      if (state !== 2'd2) begin n_fail++; $display("FAIL rearm_state got=%0d exp=2", state); end
      test_reset();
   endtask

   task automatic test_random();
      bit a_arm, a_abort;
      for (int r = 0; r < 6; r++) begin
         do_arm(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? 80 : int'($urandom_range(0, 12)));
         for (int c = 0; c < 300; c++) begin
            a_arm   = ($urandom_range(0, 199) == 0);
            a_abort = ($urandom_range(0, 149) == 0);
            if (a_arm) begin
               wrap_mode  = 1'($urandom_range(0, 1));
               trig_pc_en = 1'($urandom_range(0, 1));
               trig_pc    = 32'(4 * $urandom_range(0, 7));
               post_cnt   = CNT_W'($urandom_range(0, 90));
            end
            step(a_arm, a_abort, ($urandom_range(0, 9) < 7), 32'(4 * $urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0));
            n_tests += 8;
            if (state !== 2'(m_state))
               begin n_fail++; $display("FAIL rnd_state r=%0d c=%0d got=%0d exp=%0d", r, c, state, m_state); end
            if (count !== CW'(m_q.size()))
               begin n_fail++; $display("FAIL rnd_count r=%0d c=%0d got=%0d exp=%0d", r, c, count, m_q.size()); end
            if (empty !== (m_q.size() == 0))
               begin n_fail++; $display("FAIL rnd_empty r=%0d c=%0d got=%0b exp=%0b", r, c, empty, m_q.size() == 0); end
            if (full !== (m_q.size() == DEPTH))
               begin n_fail++; $display("FAIL rnd_full r=%0d c=%0d got=%0b exp=%0b", r, c, full, m_q.size() == DEPTH); end
            if (lost !== m_lost)
               begin n_fail++; $display("FAIL rnd_lost r=%0d c=%0d got=%0b exp=%0b", r, c, lost, m_lost); end
            if (cycle_cnt !== m_cycle)
               begin n_fail++; $display("FAIL rnd_cycle r=%0d c=%0d got=%0d exp=%0d", r, c, cycle_cnt, m_cycle); end
            if (rd_vld !== m_rd_vld)
               begin n_fail++; $display("FAIL rnd_rd_vld r=%0d c=%0d got=%0b exp=%0b", r, c, rd_vld, m_rd_vld); end
            if (rd_data !== m_rd_data)
               begin n_fail++; $display("FAIL rnd_rd_data r=%0d c=%0d got=%h exp=%h", r, c, rd_data, m_rd_data); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_immediate();
      test_history();
      test_stall();
      test_nowrap_full();
      test_back_to_back();
      test_abort_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nf_pipe_trace.md
Name: nf_pipe_trace

Overview:
- Synthesizable on-chip successor to the simulation-only pipeline tracer.
- Captures, per retiring cycle, the cycle count, fetch PC and the instruction word held in each of STAGES pipeline stages into a circular trace RAM.
- Supports trigger-on-PC, pre-trigger history and a programmable post-trigger window; a host (debug/UART bridge) drains entries through a pop handshake.
- Sits beside nf_cpu inside nf_top, fed from the stage instruction registers.

Parameters:
STAGES, 4, number of pipeline stages traced (ID, EXE, MEM, WB at default)
DEPTH, 64, trace entries, power of two, >= 4
CYC_W, 32, width of cycle counter field
CNT_W, 16, width of post-trigger count

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
arm  in  1  pulse: clear buffer and counters, enter ARMED
abort  in  1  pulse: return to IDLE, buffer contents kept
wrap_mode  in  1  1 = keep pre-trigger history (overwrite oldest); 0 = capture only after trigger, stop when full
trig_pc_en  in  1  1 = trigger on PC match; 0 = trigger immediately after arm
trig_pc  in  32  trigger PC value
post_cnt  in  CNT_W  entries captured after (and including) trigger entry
cpu_vld  in  1  pipeline advanced this cycle (not stalled)
pc_in  in  32  fetch PC (addr_i)
instr_in  in  STAGES*32  stage instruction words, stage 0 in LSBs
rd_en  in  1  pop request
rd_data  out  CYC_W+32+STAGES*32  {cycle, pc, instr}
rd_vld  out  1  rd_data valid
empty  out  1  no entries
full  out  1  DEPTH entries held
count  out  $clog2(DEPTH)+1  entries held
lost  out  1  sticky: entry overwritten in wrap mode
state  out  2  current FSM state
cycle_cnt  out  CYC_W  cycles with cpu_vld since arm

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE, pointers/count=0, empty=1, full=0, rd_vld=0, rd_data=0, lost=0, cycle_cnt=0. Reset mid-capture discards everything.
- States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE/DONE + arm -> ARMED; arm clears pointers, count, lost, cycle_cnt, and latches post_cnt, trig_pc, wrap_mode, trig_pc_en. arm in ARMED/CAPTURE restarts identically.
- abort (any state) -> IDLE next cycle; no write that cycle; abort has priority over arm.
- cycle_cnt increments on every cpu_vld in ARMED or CAPTURE, wraps at 2^CYC_W; the entry stores the pre-increment value.
- "Capture" = write entry at wr_ptr when cpu_vld.
- ARMED: trigger = cpu_vld && (!trig_pc_en || pc_in==trig_pc). With wrap_mode=1, every cpu_vld cycle is captured. With wrap_mode=0, only the trigger cycle is captured. The trigger cycle is always written and counts as post entry 1. Trigger -> CAPTURE, or -> DONE if latched post_cnt<=1. post_cnt=0 is treated as 1.
- CAPTURE: capture each cpu_vld. After the post_cnt-th entry -> DONE.
- wrap_mode=0 full: when count reaches DEPTH -> DONE, no overwrite.
- Write when full in wrap_mode: overwrite oldest, advance rd_ptr, count unchanged, lost=1.
- Read: rd_en && !empty pops; rd_data/rd_vld registered, 1-cycle latency. rd_en when empty: rd_vld=0, no pointer change.
- Reads are legal in any state. A simultaneous pop and write leaves count unchanged. Simultaneous pop and overwrite-when-full: the popped entry is the oldest, read before overwrite; rd_ptr advances once, count becomes DEPTH-1+1.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- No capture in IDLE/DONE.

Decomposition:
- Package nf_trace_pkg: state enum (IDLE/ARMED/CAPTURE/DONE), entry width function of STAGES/CYC_W, field offset constants.
- Sub-module nf_trace_ram: simple dual-port RAM, registered read, one write port, one read port, parametrised width/depth.
- FSM, pointers and counters stay in nf_pipe_trace.

Test Plan:
- Immediate trigger: trig_pc_en=0, wrap=0, post_cnt=5, cpu_vld=1 continuous after arm -> state DONE after 5 writes; count=5; pops return cycle 0..4 with matching pc/instr; 6th pop gives rd_vld=0.
- PC trigger with history: wrap=1, DEPTH=64, trig_pc=0x100, PC stepping by 4 from 0 with cpu_vld=1, post_cnt=8 -> 64 pre-trigger cycles overflow and set lost=1. Trigger at cycle 64. DONE after cycle 71. count=64, oldest pop cycle=8, newest cycle=71.
- Stall handling: cpu_vld toggling 1,0,0,1 during CAPTURE -> only 2 entries written, cycle fields consecutive (n, n+1).
- Non-wrap full: wrap=0, post_cnt=100, DEPTH=64 -> DONE at count=64; lost=0; further cpu_vld writes nothing.
- Concurrent read/write: pop every cycle during CAPTURE with post_cnt=10 -> count stays at 1 after the first write; 10 entries read in order; empty=1 at end.
- abort and reset: abort mid-CAPTURE -> IDLE, buffer readable with prior count. resetn=0 mid-CAPTURE for one edge -> all outputs return to reset values.
